// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution controller: opcodes, flag bit
// positions, FSM encoding and the opcode-to-flag-class helper.
package alu_pkg;

    localparam logic [3:0] OP_NOT  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_DEC  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0111;
    localparam logic [3:0] OP_MOV  = 4'b1000;
    localparam logic [3:0] OP_RLCY = 4'b1001;
    localparam logic [3:0] OP_TEST = 4'b1010;
    localparam logic [3:0] OP_RRCY = 4'b1011;
    localparam logic [3:0] OP_SL   = 4'b1100;
    localparam logic [3:0] OP_SR   = 4'b1101;
    localparam logic [3:0] OP_RL   = 4'b1110;
    localparam logic [3:0] OP_RR   = 4'b1111;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LEER     = 2'd1,
        ST_EJECUTAR = 2'd2,
        ST_ESCRIBIR = 2'd3
    } state_t;

    // How an opcode touches C and V (Z and N always follow the result).
    typedef enum logic [1:0] {
        CLS_LOGIC = 2'd0,   // C, V kept; carry input ignored
        CLS_ADD   = 2'd1,   // C = carry, V from addition rule
        CLS_SUB   = 2'd2,   // C = borrow, V from subtraction rule
        CLS_SHIFT = 2'd3    // C = shifted-out bit, V kept
    } op_cls_t;

    function automatic op_cls_t op_class(input logic [3:0] op);
        case (op)
            OP_ADD, OP_INC:                                    return CLS_ADD;
            OP_SUB, OP_DEC, OP_TEST:                           return CLS_SUB;
            OP_SL, OP_SR, OP_RL, OP_RR, OP_RLCY, OP_RRCY:      return CLS_SHIFT;
            OP_NOT, OP_AND, OP_OR, OP_XOR, OP_MOV:             return CLS_LOGIC;
            default:                                           return CLS_LOGIC;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake plus the operand/result bus to the external ALU.
// master = instruction source / ALU side, slave = controller.
interface alu_exec_ctrl_if #(parameter int DATA_W = 16);
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              done;
    logic [3:0]        alu_selector;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_salida;
    logic              alu_acarreo;

    modport master (
        output instr, instr_valid, alu_salida, alu_acarreo,
        input  instr_ready, done, alu_selector, alu_a, alu_b
    );

    modport slave (
        input  instr, instr_valid, alu_salida, alu_acarreo,
        output instr_ready, done, alu_selector, alu_a, alu_b
    );
endinterface

// File: rtl/banco_registros.sv
// NREG x DATA_W register bank: one synchronous write port, three
// combinational read ports (two operands plus debug).
module banco_registros #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [$clog2(NREG)-1:0] ra_addr,
    output logic [DATA_W-1:0]       ra_data,
    input  logic [$clog2(NREG)-1:0] rb_addr,
    output logic [DATA_W-1:0]       rb_data,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data
);

    logic [NREG-1:0][DATA_W-1:0] mem;

    // Write port; every entry (R0 included) is an ordinary register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  mem        <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencer around an external 16-bit ALU: reads operands from the bank,
// presents them registered to the ALU, captures the result (or computes
// the carry rotates locally), then writes back and updates {C,V,Z,N}.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_exec_ctrl_if.slave          bus,
    output logic [3:0]              flags,
    input  logic [$clog2(NREG)-1:0] dbg_sel,
    output logic [DATA_W-1:0]       dbg_data
);

    localparam int AW  = $clog2(NREG);
    localparam int MSB = DATA_W - 1;

    state_t            state, state_nx;
    logic [3:0]        op_q;
    logic [AW-1:0]     rd_q, ra_q, rb_q;
    logic [DATA_W-1:0] ra_data, rb_data;
    logic [DATA_W-1:0] res;
    logic              cy;
    logic              we;
    logic              b_msb;
    logic [3:0]        flags_nx;
    logic              unused_instr_lsb;

    assign unused_instr_lsb = ^bus.instr[2:0];

    banco_registros #(.DATA_W(DATA_W), .NREG(NREG)) u_banco (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (rd_q),
        .wdata    (res),
        .ra_addr  (ra_q),
        .ra_data  (ra_data),
        .rb_addr  (rb_q),
        .rb_data  (rb_data),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data)
    );

    // State register; reset drops any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state, handshake, done pulse and bank write enable.
    always_comb begin
        state_nx        = state;
        bus.instr_ready = 1'b0;
        bus.done        = 1'b0;
        we              = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) state_nx = ST_LEER;
            end
            ST_LEER:     state_nx = ST_EJECUTAR;
            ST_EJECUTAR: state_nx = ST_ESCRIBIR;
            ST_ESCRIBIR: begin
                bus.done = 1'b1;
                we       = (op_q != OP_TEST);
                state_nx = ST_IDLE;
            end
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Latch the decoded instruction fields on the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            rd_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end else if (state == ST_IDLE && bus.instr_valid) begin
            op_q <= bus.instr[15:12];
            rd_q <= bus.instr[11:9];
            ra_q <= bus.instr[8:6];
            rb_q <= bus.instr[5:3];
        end
    end

    // Present operands and opcode to the ALU; they stay stable until the
    // next instruction, so they double as the latched a/b for V.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_selector <= '0;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
        end else if (state == ST_LEER) begin
            bus.alu_selector <= op_q;
            bus.alu_a        <= ra_data;
            bus.alu_b        <= rb_data;
        end
    end

    // Capture result and carry. Carry rotates bypass the ALU; logic/MOV
    // never look at alu_acarreo since it may float for those opcodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
            cy  <= 1'b0;
        end else if (state == ST_EJECUTAR) begin
            case (op_q)
                OP_RLCY: begin
                    res <= {bus.alu_a[MSB-1:0], flags[FLG_C]};
                    cy  <= bus.alu_a[MSB];
                end
                OP_RRCY: begin
                    res <= {flags[FLG_C], bus.alu_a[MSB:1]};
                    cy  <= bus.alu_a[0];
                end
                default: begin
                    res <= bus.alu_salida;
                    if (op_class(op_q) != CLS_LOGIC) cy <= bus.alu_acarreo;
                end
            endcase
        end
    end

    // Next flag value; INC/DEC use an implied b of 1, whose sign bit is 0.
    always_comb begin
        b_msb           = (op_q == OP_INC || op_q == OP_DEC) ? 1'b0 : bus.alu_b[MSB];
        flags_nx        = flags;
        flags_nx[FLG_Z] = (res == '0);
        flags_nx[FLG_N] = res[MSB];
        case (op_class(op_q))
            CLS_ADD: begin
                flags_nx[FLG_C] = cy;
                flags_nx[FLG_V] = (bus.alu_a[MSB] == b_msb) && (res[MSB] != bus.alu_a[MSB]);
            end
            CLS_SUB: begin
                flags_nx[FLG_C] = cy;
                flags_nx[FLG_V] = (bus.alu_a[MSB] != b_msb) && (res[MSB] != bus.alu_a[MSB]);
            end
            CLS_SHIFT: flags_nx[FLG_C] = cy;
            default:   ;
        endcase
    end

    // Status register commits together with the writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     flags <= '0;
        else if (state == ST_ESCRIBIR)  flags <= flags_nx;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Drives the 16-bit ALU's Selector/EntradaA/EntradaB and consumes its Salida/Acarreo outputs, closing the datapath loop.
- Holds the 8x16 register bank and the status register (C, V, Z, N).
- Sequences one instruction at a time through read, execute and writeback.
- Computes overflow, which the ALU does not produce, and implements the carry-rotate opcodes (1001 RLCy, 1011 RRCy) locally from the stored carry.

Parameters:
DATA_W, 16, datapath width; fixed by the ALU.
NREG, 8, register bank depth; register index is 3 bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
instr  input  16  instruction: [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored.
instr_valid  input  1  instr is presented.
instr_ready  output  1  controller is in IDLE and accepts instr.
done  output  1  one-cycle pulse when writeback/flag update completes.
alu_selector  output  4  opcode to the ALU, registered.
alu_a  output  16  operand A to the ALU, registered.
alu_b  output  16  operand B to the ALU, registered.
alu_salida  input  16  ALU result, combinational from alu_* outputs.
alu_acarreo  input  1  ALU carry/borrow; may be z for logic and MOV opcodes.
flags  output  4  {C,V,Z,N} status register.
dbg_sel  input  3  debug register select.
dbg_data  output  16  bank[dbg_sel], combinational.

Behaviour:
- Reset (async, rst_n=0):
  - bank entries, flags, alu_selector, alu_a and alu_b all clear to 0.
  - done=0; state=IDLE, so instr_ready=1 once rst_n deasserts.
  - Reset mid-instruction aborts it: no register write, no flag update.
- FSM:
  - IDLE: instr_ready=1. A transfer occurs when instr_valid && instr_ready. Latch opcode, rd, ra, rb, then go to LEER.
  - LEER: alu_a<=bank[ra], alu_b<=bank[rb], alu_selector<=opcode. Go to EJECUTAR.
  - EJECUTAR: capture the result and carry per the table below into internal registers res/cy. Go to ESCRIBIR.
  - ESCRIBIR: bank[rd]<=res, except for TEST (1010). Update flags, pulse done, return to IDLE.
- Latency: transfer in cycle 0, done asserted in cycle 3. Throughput is one instruction per 4 cycles.
- instr_valid while not ready is ignored; the source holds the instruction until the transfer.
- Result and carry source:
  - Opcodes 1001/1011 take res/cy from local logic:
    - RLCy: res={a[14:0],C}, cy=a[15].
    - RRCy: res={C,a[15:1]}, cy=a[0].
  - All other opcodes: res=alu_salida, cy=alu_acarreo.
- Flag rules (a, b are the latched operands; r is res):
  - Z = (r==0) and N = r[15] for every opcode, including TEST.
  - Logic and MOV (0000-0011, 1000): C and V unchanged; alu_acarreo is never sampled.
  - ADD (0101), INC (0111): C=cy; V=(a15==b15)&&(r15!=a15), where b is treated as 0x0001 for INC.
  - SUB (0110), DEC (0100), TEST (1010): C=cy (borrow); V=(a15!=b15)&&(r15!=a15), where b is treated as 0x0001 for DEC.
  - Shifts/rotates (1100-1111, 1001, 1011): C=cy; V unchanged.
- Register bank:
  - All 8 registers are writable, including R0.
  - rd may equal ra or rb; the operands were already captured in LEER.
  - dbg_data returns the old value during ESCRIBIR and the new value from the next cycle.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_NOT..OP_RR (4'b0000..4'b1111, including OP_RLCY=4'b1001 and OP_RRCY=4'b1011);
  - flag bit indices FLG_C=3, FLG_V=2, FLG_Z=1, FLG_N=0;
  - FSM state encoding.
- One sub-module: banco_registros (8x16, one write port, three async read ports: ra, rb, dbg).
- The FSM and flag logic stay in the top module.

Test Plan:
- Reset, then ADD with R1=0x7FFF, R2=0x0001 into R3 (bank preloaded via MOV/INC sequences) -> R3=0x8000, flags C=0 V=1 Z=0 N=1; done exactly 3 cycles after the transfer.
- SUB R4=0x0003 minus R5=0x0005 -> result 0xFFFE, C=1 (borrow), V=0, N=1; TEST with the same operands -> identical flags, rd unchanged.
- C=1, then RLCy on 0x4000 -> 0x8001, C=0; RRCy on 0x0001 with C=0 -> 0x0000, C=1, Z=1; alu_salida is ignored, which the bench checks by driving it to 0xDEAD.
- AND 0x0F0F & 0xF0F0 with C=1, V=1 preset and alu_acarreo=z -> 0x0000, Z=1, C and V still 1.
- Hold instr_valid high with back-to-back instructions -> instr_ready low for 3 cycles after each transfer, no instruction lost or duplicated; rd=ra case (INC R1) -> R1 incremented once.
- Assert rst_n=0 during EJECUTAR of a write to R6=0x1234 -> R6=0 after reset, flags=0, no done pulse, instr_ready=1 once rst_n deasserts.
